// File: rtl/serial_add_sub_pkg.sv
// serial_arith_pkg: shared encodings for the bit-serial adder/subtractor.
//   S_IDLE/S_RUN/S_DONE : FSM state codes
//   MODE_ADD/MODE_SUB   : operation select values on the mode input
//   state_t             : enumerated FSM state built on the codes above
package serial_arith_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/result bundle of the bit-serial adder/subtractor.
//   start, mode, a, b         : request side (driven by master)
//   busy, done, result,
//   carry_borrow              : status/result side (driven by slave)
//   overflow                  : signed overflow, only when SERIAL_ADD_SUB_OVF_EN is defined
// Modports: master = requester, slave = serial_add_sub.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_borrow;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             overflow;
`endif

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_borrow
`ifdef SERIAL_ADD_SUB_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_borrow
`ifdef SERIAL_ADD_SUB_OVF_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/serial_add_sub_cell.sv
// full_add_sub_cell: combinational 1-bit full adder / full subtractor.
//   a, b  : operand bits
//   cin   : incoming carry (add) or borrow (sub)
//   mode  : MODE_ADD or MODE_SUB
//   y     : sum / difference bit
//   cout  : outgoing carry (add) or borrow (sub)
import serial_arith_pkg::*;

module full_add_sub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic y,
    output logic cout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign y       = a_xor_b ^ cin;
    // Borrow form: borrow when b exceeds a, or a==b and a borrow came in.
    assign cout    = (mode == MODE_SUB) ? ((~a & b) | (cin & ~a_xor_b))
                                        : ((a & b)  | (cin & a_xor_b));

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (aborts any operation in flight)
//   bus  : serial_add_sub_if.slave (start/mode/a/b in; busy/done/result/carry_borrow out)
// Optional: define SERIAL_ADD_SUB_OVF_EN to add the signed overflow output.
// Timing: start accepted at edge k, bits processed at edges k+1..k+WIDTH, result
// registers load at edge k+WIDTH and done pulses for the following cycle.
import serial_arith_pkg::*;

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_sub_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cb_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             cell_y;
    logic             cell_cout;
    logic [WIDTH-1:0] res_sh_next;
    logic             last_bit;

    full_add_sub_cell u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .mode (mode_reg),
        .y    (cell_y),
        .cout (cell_cout)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign res_sh_next = {cell_y, res_sh_reg[WIDTH-1:1]};
    assign last_bit    = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic ovf_reg;
    logic ovf_next;
    // On the last bit the operand shift regs present the latched MSBs at bit 0
    // and the cell output is the result MSB, so no extra MSB flops are needed.
    always_comb begin
        ovf_next = 1'b0;
        if (mode_reg == MODE_ADD)
            ovf_next = (a_sh_reg[0] == b_sh_reg[0]) && (cell_y != a_sh_reg[0]);
        else
            ovf_next = (a_sh_reg[0] != b_sh_reg[0]) && (cell_y != a_sh_reg[0]);
    end
    assign bus.overflow = ovf_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            mode_reg   <= MODE_ADD;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            result_reg <= '0;
            cb_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        mode_reg  <= bus.mode;
                        carry_reg <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end else if (state_reg == ST_DONE) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_sh_reg <= res_sh_next;
                    carry_reg  <= cell_cout;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        result_reg <= res_sh_next;
                        cb_reg     <= cell_cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
                        ovf_reg    <= ovf_next;
`endif
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.result       = result_reg;
    assign bus.carry_borrow = cb_reg;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed-vector bench for serial_add_sub (WIDTH=8).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at the
// same offset. Overflow is checked only when SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus_if ();

    serial_add_sub #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Wait for done, counting edges since the accept edge; returns 99 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt, input bit disturb);
        lat      = 0;
        busy_cnt = (bus_if.busy === 1'b1) ? 1 : 0;
        while (lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (disturb && lat == 3) begin
                bus_if.start = 1'b1;
                bus_if.mode  = 1'b1;
                bus_if.a     = 8'h11;
                bus_if.b     = 8'h77;
            end else if (disturb && lat == 4) begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done === 1'b1) break;
            if (bus_if.busy === 1'b1) busy_cnt++;
        end
        if (bus_if.done !== 1'b1) lat = 99;
    endtask

    // One full operation: pulse start, wait for done, check everything.
    task automatic do_op(input string name, input logic m, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] exp_r,
                         input logic exp_cb, input logic exp_ovf, input bit disturb);
        int lat;
        int bcnt;
        bus_if.start = 1'b1;
        bus_if.mode  = m;
        bus_if.a     = x;
        bus_if.b     = y;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        wait_done(lat, bcnt, disturb);
        $display("op %s: mode=%0d a=%02h b=%02h -> result=%02h cb=%0d latency=%0d",
                 name, m, x, y, bus_if.result, bus_if.carry_borrow, lat);
        check({name, "_latency"}, lat, 8);
        check({name, "_busy"}, bcnt, 8);
        check({name, "_result"}, bus_if.result, exp_r);
        check({name, "_cb"}, bus_if.carry_borrow, exp_cb);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check({name, "_ovf"}, bus_if.overflow, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, bus_if.done, 0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int gap;
        bit saw_done;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.mode  = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_result", bus_if.result, 0);
        check("rst_cb", bus_if.carry_borrow, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("sub_05_03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        do_op("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op("sub_eq",    1'b1, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op("add_10_20", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op("add_3c_4b", 1'b0, 8'h3C, 8'h4B, 8'h87, 1'b0, 1'b1, 1'b0);
        do_op("disturb",   1'b0, 8'hA3, 8'h25, 8'hC8, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start held through DONE with the second operands.
        bus_if.start = 1'b1;
        bus_if.mode  = 1'b1;
        bus_if.a     = 8'h20;
        bus_if.b     = 8'h30;
        @(posedge clk);
        #1;
        bus_if.mode = 1'b0;
        bus_if.a    = 8'h99;
        bus_if.b    = 8'h99;
        wait_done(lat, bcnt, 1'b0);
        $display("op b2b_first: result=%02h cb=%0d latency=%0d", bus_if.result, bus_if.carry_borrow, lat);
        check("b2b1_latency", lat, 8);
        check("b2b1_result", bus_if.result, 8'hF0);
        check("b2b1_cb", bus_if.carry_borrow, 1);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("b2b1_ovf", bus_if.overflow, 0);
`endif
        gap = 0;
        saw_done = 1'b0;
        while (gap < 30) begin
            @(posedge clk);
            #1;
            gap++;
            bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
        end
        $display("op b2b_second: result=%02h cb=%0d gap=%0d", bus_if.result, bus_if.carry_borrow, gap);
        check("b2b_gap", saw_done ? gap : 99, 9);
        check("b2b2_result", bus_if.result, 8'h32);
        check("b2b2_cb", bus_if.carry_borrow, 1);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("b2b2_ovf", bus_if.overflow, 1);
`endif
        @(posedge clk);
        #1;

        // Reset during RUN aborts the operation.
        bus_if.start = 1'b1;
        bus_if.mode  = 1'b0;
        bus_if.a     = 8'h55;
        bus_if.b     = 8'h11;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_before", bus_if.busy, 1);
        rst = 1'b1;
        #1;
        $display("op abort: busy=%0d done=%0d result=%02h cb=%0d",
                 bus_if.busy, bus_if.done, bus_if.result, bus_if.carry_borrow);
        check("abort_busy", bus_if.busy, 0);
        check("abort_done", bus_if.done, 0);
        check("abort_result", bus_if.result, 0);
        check("abort_cb", bus_if.carry_borrow, 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("abort_ovf", bus_if.overflow, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        do_op("after_abort", 1'b0, 8'h0F, 8'hF1, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
